// File: rtl/face_rotate_ctrl.sv
// -----------------------------------------------------------------------------
// face_rotate_ctrl
//   Sequencer for one 3x3 cube-face RAM. On start it reads all nine stickers
//   into a local buffer, then writes them back rotated (identity, CW, CCW or
//   180 deg). While idle the host port is passed straight through to the RAM.
//
//   Optional build macro: FACE_CENTER_SKIP_EN
//     defined   : the center cell (i=4) is neither read nor written
//                 (8 reads + 16 write cycles).
//     undefined : all nine cells are read and rewritten.
//
// Ports
//   clk, clear             clock, synchronous active-high reset
//   start, dir             rotate request and direction (captured on accept)
//   busy, done             operation in progress / one-cycle completion pulse
//   host_addr1/2, host_we,
//   host_data, host_q      host access port (row, col, write, data, read data)
//   ram_addr1/2, ram_we,
//   ram_data, ram_q        face RAM port (ram_q is combinational read data)
// -----------------------------------------------------------------------------
module face_rotate_ctrl #(
   parameter int S_DATA = 16
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [1:0]        dir,
   output logic              busy,
   output logic              done,
   input  logic [1:0]        host_addr1,
   input  logic [1:0]        host_addr2,
   input  logic              host_we,
   input  logic [S_DATA-1:0] host_data,
   output logic [S_DATA-1:0] host_q,
   output logic [1:0]        ram_addr1,
   output logic [1:0]        ram_addr2,
   output logic              ram_we,
   output logic [S_DATA-1:0] ram_data,
   input  logic [S_DATA-1:0] ram_q
);

   typedef enum logic [2:0] {IDLE, READ, WSETUP, WRITE, DONE} state_t;

   state_t            state, state_nx;
   logic [3:0]        idx, idx_nx;
   logic [1:0]        dir_r;
   logic [S_DATA-1:0] cell_buf [9];
   logic [1:0]        cur_row, cur_col;

   // cell index -> {row, col}
   function automatic logic [3:0] rc_of(input logic [3:0] i);
      logic [3:0] rc;
      case (i)
         4'd0:    rc = 4'b00_00;
         4'd1:    rc = 4'b00_01;
         4'd2:    rc = 4'b00_10;
         4'd3:    rc = 4'b01_00;
         4'd4:    rc = 4'b01_01;
         4'd5:    rc = 4'b01_10;
         4'd6:    rc = 4'b10_00;
         4'd7:    rc = 4'b10_01;
         4'd8:    rc = 4'b10_10;
         default: rc = 4'b00_00;
      endcase
      return rc;
   endfunction

   // destination cell -> buffered source cell for the selected rotation
   function automatic logic [3:0] src_of(input logic [3:0] i, input logic [1:0] d);
      logic [1:0] r, c, sr, sc;
      {r, c} = rc_of(i);
      case (d)
         2'b01:   begin sr = 2'd2 - c; sc = r;        end // CW
         2'b10:   begin sr = c;        sc = 2'd2 - r; end // CCW
         2'b11:   begin sr = 2'd2 - r; sc = 2'd2 - c; end // 180
         default: begin sr = r;        sc = c;        end // identity
      endcase
      return {2'b00, sr} * 4'd3 + {2'b00, sc};
   endfunction

   // next cell to visit; the center never moves, so it can be skipped
   function automatic logic [3:0] nxt(input logic [3:0] i);
`ifdef FACE_CENTER_SKIP_EN
      return (i == 4'd3) ? 4'd5 : i + 4'd1;
`else
      return i + 4'd1;
`endif
   endfunction

   assign {cur_row, cur_col} = rc_of(idx);
   assign host_q             = ram_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         state <= IDLE;
         idx   <= 4'd0;
         dir_r <= 2'b00;
         for (int k = 0; k < 9; k++) cell_buf[k] <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (state == IDLE && start) dir_r <= dir;
         if (state == READ) cell_buf[idx] <= ram_q;
      end
   end

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      busy      = 1'b0;
      done      = 1'b0;
      ram_addr1 = cur_row;
      ram_addr2 = cur_col;
      ram_we    = 1'b0;
      ram_data  = cell_buf[src_of(idx, dir_r)];
      case (state)
         IDLE: begin
            ram_addr1 = host_addr1;
            ram_addr2 = host_addr2;
            ram_we    = host_we;
            ram_data  = host_data;
            if (start) begin
               state_nx = READ;
               idx_nx   = 4'd0;
            end
         end
         READ: begin
            busy = 1'b1;
            if (idx == 4'd8) begin
               state_nx = WSETUP;
               idx_nx   = 4'd0;
            end else begin
               idx_nx = nxt(idx);
            end
         end
         // RAM latches the address while we=0, so each write needs a setup cycle
         WSETUP: begin
            busy     = 1'b1;
            state_nx = WRITE;
         end
         WRITE: begin
            busy   = 1'b1;
            ram_we = 1'b1;
            if (idx == 4'd8) begin
               state_nx = DONE;
            end else begin
               state_nx = WSETUP;
               idx_nx   = nxt(idx);
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
            idx_nx   = 4'd0;
         end
         default: begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
         end
      endcase
   end

endmodule
